spi_master_ram_ctrl: RTL and testbench

- SPI master that drives the existing SPI slave with single-port RAM over SS_n/MOSI/MISO, all on one shared clk.
- A local host issues one 2-bit command plus an 8-bit payload per transaction. The block frames it on SS_n/MOSI and, for read-data commands, shifts the returned byte in from MISO.
- Used as the initiator in system-level RAM access and as the self-checking stimulus source for slave regression.

---
 rtl/spi_master_ram_ctrl_pkg.sv | 34 +++
 rtl/spi_master_ram_ctrl_if.sv | 16 +
 rtl/spi_master_ram_ctrl_shift_reg.sv | 25 ++
 rtl/spi_master_ram_ctrl.sv | 149 ++++++++++++++
 tb/tb_spi_master_ram_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_ram_ctrl_pkg.sv
// Shared command encodings, FSM states and frame sizing for the SPI RAM master.
// Latency: none (types/constants only); backpressure: not applicable.
package spi_master_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT_OUT,
        ST_WAIT_RD,
        ST_SHIFT_IN,
        ST_GAP
    } state_e;

    localparam int CMD_W     = 2;
    localparam int FRAME_LEN = 10;

    // One counter serves every phase, so it must reach the longest terminal count.
    function automatic int cnt_width(input int data_w, input int rd_wait, input int gap);
        int m;
        m = FRAME_LEN;
        if (CMD_W + data_w > m) m = CMD_W + data_w;
        if (rd_wait > m)        m = rd_wait;
        if (gap > m)            m = gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_master_ram_ctrl_if.sv
// Host-side request/response bundle of the SPI RAM master.
// Latency: wires only; backpressure: start is ignored while busy is high.
interface spi_master_ram_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic              start;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport master (output start, cmd, tx_data, input busy, done, rx_data, rx_valid);
    modport slave  (input start, cmd, tx_data, output busy, done, rx_data, rx_valid);
endinterface

// File: rtl/spi_master_ram_ctrl_shift_reg.sv
// Parallel-load, left-shift register with serial input; MSB is the serial output.
// Latency: one cycle per load/shift; backpressure: none, load wins over shift.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], sin};
        end
    end

endmodule

// File: rtl/spi_master_ram_ctrl.sv
// SPI master framing {cmd,tx_data} onto SS_n/MOSI and reading a byte back from MISO for cmd 11.
// Latency: done 11+GAP edges after start (writes), 18+RD_WAIT+GAP (read-data); start ignored while busy.
module spi_master_ram_ctrl
    import spi_master_ram_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_master_ram_ctrl_if.slave  host,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int TX_W = CMD_W + DATA_W;
    localparam int CW   = cnt_width(DATA_W, RD_WAIT, GAP);

    state_e            state;
    cmd_e              cmd_q;
    logic [CW-1:0]     cnt;
    logic              busy_q;
    logic              done_q;
    logic              rxv_q;
    logic [DATA_W-1:0] rx_q;
    logic [TX_W-1:0]   tx_q;
    logic [DATA_W-1:0] rx_sr;
    logic              tx_load;
    logic              tx_shift;
    logic              rx_shift;
    logic              unused_tx;

    assign unused_tx = ^tx_q[TX_W-2:0];

    always_comb begin
        tx_load  = (state == ST_IDLE) && host.start;
        tx_shift = (state == ST_SEL) || ((state == ST_SHIFT_OUT) && (cnt != CW'(TX_W)));
        // First MISO sample is taken on the edge that leaves WAIT_RD.
        rx_shift = ((state == ST_WAIT_RD) && (cnt == CW'(RD_WAIT - 1))) || (state == ST_SHIFT_IN);
    end

    spi_shift_reg #(.W(TX_W)) u_tx_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load),
        .din   ({host.cmd, host.tx_data}),
        .shift (tx_shift),
        .sin   (1'b0),
        .q     (tx_q)
    );

    spi_shift_reg #(.W(DATA_W)) u_rx_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (1'b0),
        .din   ('0),
        .shift (rx_shift),
        .sin   (MISO),
        .q     (rx_sr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cmd_q  <= CMD_WR_ADDR;
            cnt    <= '0;
            SS_n   <= 1'b1;
            MOSI   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rxv_q  <= 1'b0;
            rx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            rxv_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host.start) begin
                        cmd_q  <= cmd_e'(host.cmd);
                        SS_n   <= 1'b0;
                        MOSI   <= host.cmd[1];
                        busy_q <= 1'b1;
                        state  <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    MOSI  <= tx_q[TX_W-1];
                    cnt   <= CW'(1);
                    state <= ST_SHIFT_OUT;
                end
                ST_SHIFT_OUT: begin
                    if (cnt == CW'(TX_W)) begin
                        MOSI <= 1'b0;
                        cnt  <= '0;
                        if (cmd_q == CMD_RD_DATA) begin
                            state <= ST_WAIT_RD;
                        end else begin
                            SS_n  <= 1'b1;
                            state <= ST_GAP;
                        end
                    end else begin
                        MOSI <= tx_q[TX_W-1];
                        cnt  <= cnt + 1'b1;
                    end
                end
                ST_WAIT_RD: begin
                    if (cnt == CW'(RD_WAIT - 1)) begin
                        cnt   <= CW'(1);
                        state <= ST_SHIFT_IN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT_IN: begin
                    if (cnt == CW'(DATA_W - 1)) begin
                        cnt   <= '0;
                        SS_n  <= 1'b1;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == CW'(GAP - 1)) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                        if (cmd_q == CMD_RD_DATA) begin
                            rxv_q <= 1'b1;
                            rx_q  <= rx_sr;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.rx_valid = rxv_q;
    assign host.rx_data  = rx_q;

endmodule

// File: tb/tb_spi_master_ram_ctrl.sv
// Random and directed transactions against a behavioural SPI slave/RAM and a host-level reference model.
module tb_spi_master_ram_ctrl;
    import spi_master_ram_ctrl_pkg::*;

    localparam int DATA_W  = 8;
    localparam int RD_WAIT = 2;
    localparam int GAP     = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SS_n;
    logic MOSI;
    logic MISO = 1'b0;

    spi_master_ram_ctrl_if #(.DATA_W(DATA_W)) hif ();

    spi_master_ram_ctrl #(.DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (hif.slave),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural slave: frames are counted in negedges after SS_n falls; the first
    // negedge sees the duplicated cmd[1], bits follow on negedges 2..11.
    logic [7:0] mem [256];
    logic [7:0] s_waddr = 8'h00;
    logic [7:0] s_raddr = 8'h00;
    logic [9:0] sh = '0;
    logic [9:0] last_frame = '0;
    logic [7:0] sbyte;
    int         n = 0;

    always @(negedge clk) begin
        MISO = 1'($urandom_range(0, 1));
        if (SS_n) begin
            n = 0;
        end else begin
            n++;
            if (n >= 2 && n <= 11) sh = {sh[8:0], MOSI};
            if (n == 11) begin
                last_frame = sh;
                case (sh[9:8])
                    2'b00:   s_waddr = sh[7:0];
                    2'b01:   mem[s_waddr] = sh[7:0];
                    2'b10:   s_raddr = sh[7:0];
                    default: ;
                endcase
            end
            if (n >= 11 + RD_WAIT && n < 19 + RD_WAIT && sh[9:8] == 2'b11) begin
                sbyte = mem[s_raddr];
                MISO  = sbyte[18 + RD_WAIT - n];
            end
        end
    end

    // Host-level reference: what the RAM should hold given the commands issued.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_waddr = 8'h00;
    logic [7:0] ref_raddr = 8'h00;
    logic [7:0] exp_rx    = 8'h00;

    int hi_run   = 0;
    int min_hi   = 1000;
    bit seen_low = 1'b0;

    always @(posedge clk) begin
        #1;
        if (SS_n) begin
            hi_run++;
        end else begin
            if (seen_low && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
            hi_run   = 0;
            seen_low = 1'b1;
        end
    end

    task automatic run_txn(input logic [1:0] c, input logic [7:0] d, input bit keep, input bit inject);
        logic [10:0] mseq;
        int lat;
        int ss_lo;
        int rxv_n;
        int exp_lat;
        mseq  = '0;
        lat   = 0;
        rxv_n = 0;
        hif.start   = 1'b1;
        hif.cmd     = c;
        hif.tx_data = d;
        @(posedge clk); #1;
        if (!keep) hif.start = 1'b0;
        check("ss_fall", SS_n, 1'b0);
        check("busy_start", hif.busy, 1'b1);
        mseq[10] = MOSI;
        ss_lo    = 1;
        for (int j = 1; j <= 40; j++) begin
            if (inject && j == 4) begin
                hif.start = 1'b1;
                hif.cmd   = 2'b11;
            end
            if (inject && j == 5) hif.start = 1'b0;
            @(posedge clk); #1;
            if (j <= 10) mseq[10 - j] = MOSI;
            if (!SS_n) ss_lo++;
            if (hif.rx_valid) rxv_n++;
            if (hif.done) begin
                lat = j;
                break;
            end
        end
        case (c)
            2'b00:   ref_waddr = d;
            2'b01:   ref_mem[ref_waddr] = d;
            2'b10:   ref_raddr = d;
            default: exp_rx = ref_mem[ref_raddr];
        endcase
        exp_lat = (c == 2'b11) ? 18 + RD_WAIT + GAP : 11 + GAP;
        check("done_latency", lat, exp_lat);
        check("mosi_seq", mseq, {c[1], c, d});
        check("slave_frame", last_frame, {c, d});
        if (c != 2'b11) check("ss_low_cycles", ss_lo, 11);
        check("rx_valid_count", rxv_n, (c == 2'b11) ? 1 : 0);
        check("rx_data", hif.rx_data, exp_rx);
        check("busy_at_done", hif.busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dn;
        int rv;
        logic [1:0] c;
        logic [7:0] d;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v          = 8'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        hif.start   = 1'b0;
        hif.cmd     = 2'b00;
        hif.tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", SS_n, 1'b1);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_busy", hif.busy, 1'b0);
        check("rst_done", hif.done, 1'b0);
        check("rst_rx_valid", hif.rx_valid, 1'b0);
        check("rst_rx_data", hif.rx_data, 8'h00);
        rst = 1'b0;

        // Reset in the middle of a read-data frame.
        @(negedge clk);
        hif.start = 1'b1; hif.cmd = 2'b11; hif.tx_data = 8'($urandom);
        @(posedge clk); #1;
        hif.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ss_n", SS_n, 1'b1);
        check("abort_busy", hif.busy, 1'b0);
        check("abort_mosi", MOSI, 1'b0);
        rst = 1'b0;
        dn = 0;
        rv = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (hif.done) dn++;
            if (hif.rx_valid) rv++;
        end
        check("abort_no_done", dn, 0);
        check("abort_no_rx_valid", rv, 0);
        check("abort_rx_kept", hif.rx_data, exp_rx);

        @(negedge clk); run_txn(2'b00, 8'h5A, 1'b0, 1'b0);

        @(negedge clk); run_txn(2'b10, 8'h33, 1'b0, 1'b0);
        mem[8'h33] = 8'hC3;
        ref_mem[8'h33] = 8'hC3;
        @(negedge clk); run_txn(2'b11, 8'($urandom), 1'b0, 1'b0);
        check("read_c3", hif.rx_data, 8'hC3);

        @(negedge clk); run_txn(2'b00, 8'h10, 1'b0, 1'b0);
        @(negedge clk); run_txn(2'b01, 8'hA5, 1'b0, 1'b0);
        @(negedge clk); run_txn(2'b10, 8'h10, 1'b0, 1'b0);
        @(negedge clk); run_txn(2'b11, 8'h00, 1'b0, 1'b0);
        check("loopback_a5", hif.rx_data, 8'hA5);

        // start pulsed with cmd 11 during a write frame must be ignored.
        @(negedge clk); run_txn(2'b01, 8'($urandom), 1'b0, 1'b1);
        dn = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (hif.done) dn++;
        end
        check("ignored_start_done", dn, 0);
        check("ignored_start_busy", hif.busy, 1'b0);

        // start held high across two commands.
        @(negedge clk);
        run_txn(2'b00, 8'h07, 1'b1, 1'b0);
        run_txn(2'b11, 8'h00, 1'b0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            c = 2'($urandom);
            d = (c == 2'b01) ? 8'($urandom) : 8'($urandom_range(0, 7));
            @(negedge clk);
            run_txn(c, d, 1'b0, 1'b0);
        end

        check("min_ss_high", (min_hi >= GAP) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
